// File: rtl/mem_access_unit.sv
// Memory-access stage: latches the effective address into MAR and runs a direct
// or indirect (pointer-then-data) memory transaction, returning load data via MDR.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC1 = 3'd1;
    localparam logic [2:0] S_IND  = 3'd2;
    localparam logic [2:0] S_ACC2 = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_LDI = 2'd2;
    localparam logic [1:0] OP_STI = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [15:0]      mar;
    logic [15:0]      mdr;
    logic [15:0]      sdr;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             timed_out;

    // Handshake: mem_en holds mem_addr/mem_we/mem_wdata stable until an edge
    // samples mem_ready=1; each such sample completes exactly one access.
    assign timed_out = (TIMEOUT != 0) && !mem_ready && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            mar   <= '0;
            mdr   <= '0;
            sdr   <= '0;
            op_q  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mar   <= addr;
                        mdr   <= wdata;
                        sdr   <= wdata;
                        op_q  <= op;
                        cnt   <= '0;
                        err_q <= 1'b0;
                        state <= S_ACC1;
                    end
                end
                S_ACC1: begin
                    if (mem_ready) begin
                        // Reads and both indirect ops fetch data or a pointer first.
                        if (op_q != OP_WR) mdr <= mem_rdata;
                        state <= op_q[1] ? S_IND : S_DONE;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_IND: begin
                    mar <= mdr;
                    if (op_q == OP_STI) mdr <= sdr;
                    cnt   <= '0;
                    state <= S_ACC2;
                end
                S_ACC2: begin
                    if (mem_ready) begin
                        if (op_q == OP_LDI) mdr <= mem_rdata;
                        state <= S_DONE;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = err_q && (state == S_DONE);
    assign mem_en    = (state == S_ACC1) || (state == S_ACC2);
    assign mem_we    = ((state == S_ACC1) && (op_q == OP_WR)) ||
                       ((state == S_ACC2) && (op_q == OP_STI));
    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign rdata     = mdr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model builds a per-cycle output
// trace that one compare process checks, plus a ready-handshaked memory responder.
module tb_mem_access_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b0;

    logic [52:0] exp_q[$];
    logic [32:0] acc_log[$];
    logic [15:0] mem [0:65535];
    logic [15:0] m_mar = 16'h0000;
    logic [15:0] m_mdr = 16'h0000;
    int          checks = 0;
    int          failures = 0;
    int          w1_cfg = 0;
    int          w2_cfg = 0;
    int          acc_idx = 0;
    int          wcnt = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(T), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Memory responder: w1_cfg/w2_cfg ready-low cycles before the first/second access.
    always @(posedge clk) begin
        if (rst) begin
            acc_idx = 0;
            wcnt    = 0;
        end else if (start && !busy) begin
            acc_idx = 0;
            wcnt    = 0;
        end else if (mem_en && mem_ready) begin
            acc_log.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
            acc_idx = acc_idx + 1;
            wcnt    = 0;
        end else if (mem_en) begin
            wcnt = wcnt + 1;
        end
        #1;
        mem_ready = mem_en && (wcnt >= ((acc_idx == 0) ? w1_cfg : w2_cfg));
        mem_rdata = mem_ready ? mem[mem_addr] : 16'hDEAD;
    end

    function automatic logic [52:0] pk(input logic b, d, e, en, we,
                                       input logic [15:0] a, wd, rd);
        return {b, d, e, en, we, a, wd, rd};
    endfunction

    always @(negedge clk) begin : cmp_proc
        logic [52:0] ex;
        logic [52:0] ac;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            ac = pk(busy, done, err, mem_en, mem_we, mem_addr, mem_wdata, rdata);
            checks++;
            if (ac !== ex) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t busy,done,err,en,we act=%b req=%b addr act=%h req=%h wdata act=%h req=%h rdata act=%h req=%h",
                         $time, ac[52:48], ex[52:48], ac[47:32], ex[47:32],
                         ac[31:16], ex[31:16], ac[15:0], ex[15:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic b, d, e, en, we);
        exp_q.push_back(pk(b, d, e, en, we, m_mar, m_mdr, m_mdr));
    endtask

    // Transaction-level model: expected outputs from start cycle to the idle cycle after done.
    task automatic model_op(input logic [1:0] o, input logic [15:0] a, wd,
                            input int x1, x2, output int dcyc, output logic to);
        int          n;
        logic [15:0] ptr;
        push(0, 0, 0, 0, 0);
        m_mar = a;
        m_mdr = wd;
        to    = 1'b0;
        n     = (x1 >= T) ? T : x1 + 1;
        for (int i = 0; i < n; i++) push(1, 0, 0, 1, o == 2'd1);
        dcyc = n;
        if (x1 >= T) to = 1'b1;
        else if (o != 2'd1) m_mdr = mem[a];
        if (!to && o[1]) begin
            push(1, 0, 0, 0, 0);
            dcyc++;
            ptr   = m_mdr;
            m_mar = ptr;
            if (o == 2'd3) m_mdr = wd;
            n = (x2 >= T) ? T : x2 + 1;
            for (int i = 0; i < n; i++) push(1, 0, 0, 1, o == 2'd3);
            dcyc += n;
            if (x2 >= T) to = 1'b1;
            else if (o == 2'd2) m_mdr = mem[ptr];
        end
        dcyc++;
        push(1, 1, to, 0, 0);
        push(0, 0, 0, 0, 0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, wd,
                          input int x1, x2, extra, exp_d,
                          input logic [15:0] exp_mdr, input logic exp_err,
                          input int n_acc, input logic [32:0] acc0, acc1);
        int   d;
        logic to;
        int   base;
        step();
        op = o; addr = a; wdata = wd; start = 1'b1;
        w1_cfg = x1; w2_cfg = x2;
        base = acc_log.size();
        model_op(o, a, wd, x1, x2, d, to);
        chk("model_done_cycle", 64'(d), 64'(exp_d));
        chk("model_final_mdr", 64'(m_mdr), 64'(exp_mdr));
        chk("model_err", 64'(to), 64'(exp_err));
        for (int k = 1; k <= d + 1; k++) begin
            step();
            start = (k == extra);
        end
        @(negedge clk);
        #1;
        start = 1'b0;
        chk("access_count", 64'(acc_log.size() - base), 64'(n_acc));
        if (n_acc > 0) chk("access0", 64'(acc_log[base]), 64'(acc0));
        if (n_acc > 1) chk("access1", 64'(acc_log[base + 1]), 64'(acc1));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'd0; addr = 16'h0; wdata = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h3000] = 16'hBEEF;
        mem[16'h3010] = 16'h5000;
        mem[16'h5000] = 16'hCAFE;
        mem[16'h3020] = 16'hFFFF;
        mem[16'hFFFF] = 16'h1357;
        mem[16'h0040] = 16'h0000;
        mem[16'h0000] = 16'h2468;

        // Reset state
        step(); push(0, 0, 0, 0, 0);
        step(); push(0, 0, 0, 0, 0);
        step(); rst = 1'b0; push(0, 0, 0, 0, 0);

        // Direct read, zero wait states
        run_op(2'd0, 16'h3000, 16'h0000, 0, 0, -1, 2, 16'hBEEF, 1'b0,
               1, {1'b0, 16'h3000, 16'hBEEF}, '0);
        // Direct write, three wait states
        run_op(2'd1, 16'h4001, 16'h1234, 3, 0, -1, 5, 16'h1234, 1'b0,
               1, {1'b1, 16'h4001, 16'h1234}, '0);
        // LDI
        run_op(2'd2, 16'h3010, 16'h0000, 0, 0, -1, 4, 16'hCAFE, 1'b0,
               2, {1'b0, 16'h3010, 16'h5000}, {1'b0, 16'h5000, 16'hCAFE});
        // STI to 0xFFFF; start pulsed during the done cycle must be ignored
        run_op(2'd3, 16'h3020, 16'h00A5, 0, 0, 4, 4, 16'h00A5, 1'b0,
               2, {1'b0, 16'h3020, 16'hFFFF}, {1'b1, 16'hFFFF, 16'h00A5});
        // Timeout on ACC1 with a start pulse while busy
        run_op(2'd0, 16'h3000, 16'h7777, 255, 0, 2, 5, 16'h7777, 1'b1,
               0, '0, '0);
        // Following read at the top address runs cleanly
        run_op(2'd0, 16'hFFFF, 16'h0000, 0, 0, -1, 2, 16'h1357, 1'b0,
               1, {1'b0, 16'hFFFF, 16'h1357}, '0);
        // LDI through a null pointer with wait states on both accesses
        run_op(2'd2, 16'h0040, 16'h9999, 1, 2, -1, 7, 16'h2468, 1'b0,
               2, {1'b0, 16'h0040, 16'h0000}, {1'b0, 16'h0000, 16'h2468});

        // Reset during ACC2 of an LDI
        step();
        op = 2'd2; addr = 16'h3010; wdata = 16'h1111; start = 1'b1;
        w1_cfg = 0; w2_cfg = 255;
        push(0, 0, 0, 0, 0);
        m_mar = 16'h3010; m_mdr = 16'h1111;
        step(); start = 1'b0; push(1, 0, 0, 1, 0);
        step(); m_mdr = 16'h5000; push(1, 0, 0, 0, 0);
        step(); m_mar = 16'h5000; push(1, 0, 0, 1, 0);
        step(); rst = 1'b1; m_mar = 16'h0000; m_mdr = 16'h0000; push(0, 0, 0, 0, 0);
        step(); push(0, 0, 0, 0, 0);
        step(); rst = 1'b0; push(0, 0, 0, 0, 0);
        step(); push(0, 0, 0, 0, 0);
        step(); push(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        // After reset the unit behaves as from power-up
        run_op(2'd0, 16'h3000, 16'h0000, 0, 0, -1, 2, 16'hBEEF, 1'b0,
               1, {1'b0, 16'h3000, 16'hBEEF}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
